multicast_fork_serializer: RTL
==============================

Name: multicast_fork_serializer

Overview:
- Sits directly downstream of the multicast route-computation stage.
- Captures the five registered (data, direction) sub-packet pairs that stage produces, discards empty copies, and issues the surviving copies one at a time to the switch allocator over a valid/ready handshake.
- Drives rc_ready back upstream so that the route-computation registers only reload once every copy of the current multicast packet has been accepted.

Parameters:
- DATASIZE, 30, flit width; bit layout [29:25] header, [24:9] 16-bit destination list, [8:1] payload/tag, [0] valid flag
- NUM_SUB, 5, number of sub-packet inputs; fixed at 5, not intended to change

Ports:
- rc_clk  input  1  clock shared with the route-computation stage
- rst  input  1  synchronous reset, active-high
- data_in1..data_in5  input  DATASIZE each  sub-packet flits from upstream
- direction_in1..direction_in5  input  5 each  one-hot output port of each sub-packet; 0 = no copy
- rc_ready  output  1  high = block is idle and captures on this edge; upstream reloads on the same edge
- data_out  output  DATASIZE  current copy to switch allocator
- direction_out  output  5  one-hot port of current copy
- valid_out  output  1  data_out/direction_out hold a copy
- sa_ready  input  1  switch allocator accepts the copy this cycle
- copies_out  output  3  number of copies in the packet currently being issued (0..5)
- busy  output  1  high while any copy is still pending

Behaviour:
- Reset (rst=1 at a posedge):
  - state=IDLE; pending mask=0; all buffers=0.
  - data_out=0, direction_out=0, valid_out=0, copies_out=0, busy=0.
  - rc_ready is forced 0 while rst is high.
- Entry N is "live" when all of the following hold:
  - direction_inN != 0
  - data_inN[24:9] != 0
  - data_inN[0] == 1
- States: IDLE and SEND. Only two states are used; no other encodings are reachable.
- IDLE:
  - rc_ready=1, valid_out=0, busy=0.
  - At each posedge, all five data_inN/direction_inN are copied into buffers, and mask bit N is set when entry N is live.
  - If the mask is non-zero: go to SEND, and copies_out = popcount(mask) (3-bit, at most 5).
  - If the mask is zero: stay in IDLE, no output activity, and copies_out is left unchanged.
- SEND:
  - rc_ready=0, busy=1, valid_out=1.
  - Current index = lowest set bit of the mask (fixed priority 1 > 2 > 3 > 4 > 5).
  - data_out and direction_out = buffers of the current index. They come from registers through a mux, and no input-to-output combinational path is allowed.
  - Handshake: a copy transfers when valid_out and sa_ready are both 1 at a posedge. That copy's mask bit clears, and the next index appears in the following cycle.
  - Latency: first copy is valid 1 cycle after capture; back-to-back copies issue 1 per cycle when sa_ready is held high.
- Transfer of the last pending copy:
  - Next state is IDLE, so rc_ready is 1 in the following cycle. There is no bubble beyond that one cycle.
  - copies_out holds its value until the next non-empty capture.
- Stall: with sa_ready=0, data_out, direction_out and valid_out hold stable indefinitely. Upstream is frozen because rc_ready=0.
- Output values when not valid: data_out and direction_out are 0 whenever valid_out=0.
- Upstream handshake: upstream outputs are registered, so capture and upstream reload on the same rc_ready edge is lossless by construction. No additional input valid signal exists.
- Reset mid-SEND: the pending mask is cleared and the remaining copies are dropped. valid_out=0 in the cycle after the reset edge.
- Non-one-hot direction_inN: the value is passed through unchanged. Legality is not checked here.
- Changes to inputs while in SEND are ignored.

Test Plan:
- Reset then idle: rst=1 for 2 cycles -> all outputs 0 and rc_ready=0; after release rc_ready=1, valid_out=0.
- Full fan-out: all five entries live, directions 00100/00001/00010/10000/01000, sa_ready=1 -> five consecutive cycles of valid_out with directions in that order; copies_out=5; rc_ready=1 in the cycle after the 5th transfer.
- Sparse: only entries 2 and 5 live (others with direction 0 or dst field 0) -> copies_out=2; exactly two copies issued, 00001 then 01000.
- Backpressure: 3 live copies, sa_ready toggling 0,0,1,0,1,1 -> data_out stable while stalled; transfers only on sa_ready=1 cycles; rc_ready stays 0 throughout.
- Empty capture: all directions 0, or live bit data_in[0]=0 -> stays IDLE, valid_out=0, rc_ready=1, copies_out unchanged.
- Reset mid-SEND: assert rst after the 2nd of 4 copies -> valid_out=0 the next cycle; after release no residual copies appear and rc_ready=1.

Source files
------------

// File: rtl/multicast_fork_serializer.sv
// Captures the five route-computed sub-packets, drops empty copies and issues the
// survivors one per handshake to the switch allocator, lowest entry first.
module multicast_fork_serializer #(
  parameter int DATASIZE = 30,
  parameter int NUM_SUB  = 5
) (
  input  logic                rc_clk,
  input  logic                rst,
  input  logic [DATASIZE-1:0] data_in1,
  input  logic [DATASIZE-1:0] data_in2,
  input  logic [DATASIZE-1:0] data_in3,
  input  logic [DATASIZE-1:0] data_in4,
  input  logic [DATASIZE-1:0] data_in5,
  input  logic [4:0]          direction_in1,
  input  logic [4:0]          direction_in2,
  input  logic [4:0]          direction_in3,
  input  logic [4:0]          direction_in4,
  input  logic [4:0]          direction_in5,
  output logic                rc_ready,
  output logic [DATASIZE-1:0] data_out,
  output logic [4:0]          direction_out,
  output logic                valid_out,
  input  logic                sa_ready,
  output logic [2:0]          copies_out,
  output logic                busy
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t              state;
  logic [DATASIZE-1:0] data_in_a   [NUM_SUB];
  logic [4:0]          dir_in_a    [NUM_SUB];
  logic [DATASIZE-1:0] data_buf_p0 [NUM_SUB];
  logic [4:0]          dir_buf_p0  [NUM_SUB];
  logic [NUM_SUB-1:0]  live;
  logic [NUM_SUB-1:0]  pend_p0;
  logic [NUM_SUB-1:0]  pend_next;
  logic [2:0]          cur_idx;
  logic                vld_p0;

  function automatic logic is_live(input logic [15:0] dst, input logic vflag,
                                   input logic [4:0] dir);
    return (dir != 5'd0) && (dst != 16'd0) && vflag;
  endfunction

  function automatic logic [2:0] popcount(input logic [NUM_SUB-1:0] m);
    logic [2:0] c;
    c = '0;
    for (int i = 0; i < NUM_SUB; i++) c = c + 3'(m[i]);
    return c;
  endfunction

  function automatic logic [2:0] lowest_idx(input logic [NUM_SUB-1:0] m);
    logic [2:0] idx;
    idx = '0;
    for (int i = NUM_SUB - 1; i >= 0; i--) if (m[i]) idx = 3'(i);
    return idx;
  endfunction

  assign data_in_a[0] = data_in1;
  assign data_in_a[1] = data_in2;
  assign data_in_a[2] = data_in3;
  assign data_in_a[3] = data_in4;
  assign data_in_a[4] = data_in5;
  assign dir_in_a[0]  = direction_in1;
  assign dir_in_a[1]  = direction_in2;
  assign dir_in_a[2]  = direction_in3;
  assign dir_in_a[3]  = direction_in4;
  assign dir_in_a[4]  = direction_in5;

  always_comb begin
    live = '0;
    for (int i = 0; i < NUM_SUB; i++)
      live[i] = is_live(data_in_a[i][24:9], data_in_a[i][0], dir_in_a[i]);
  end

  // Clearing the lowest set bit retires exactly the copy currently on the output.
  assign pend_next = pend_p0 & (pend_p0 - 1'b1);

  // Stage p0: capture buffers and pending mask
  always_ff @(posedge rc_clk) begin
    if (rst) begin
      state      <= IDLE;
      pend_p0    <= '0;
      copies_out <= '0;
      for (int i = 0; i < NUM_SUB; i++) begin
        data_buf_p0[i] <= '0;
        dir_buf_p0[i]  <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          for (int i = 0; i < NUM_SUB; i++) begin
            data_buf_p0[i] <= data_in_a[i];
            dir_buf_p0[i]  <= dir_in_a[i];
          end
          pend_p0 <= live;
          if (live != '0) begin
            state      <= SEND;
            copies_out <= popcount(live);
          end
        end
        SEND: begin
          if (sa_ready) begin
            pend_p0 <= pend_next;
            if (pend_next == '0) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Output mux: registered buffers only, zeroed when no copy is held
  assign vld_p0        = (state == SEND);
  assign cur_idx       = lowest_idx(pend_p0);
  assign valid_out     = vld_p0;
  assign busy          = vld_p0;
  assign rc_ready      = (state == IDLE) && !rst;
  assign data_out      = vld_p0 ? data_buf_p0[cur_idx] : '0;
  assign direction_out = vld_p0 ? dir_buf_p0[cur_idx]  : '0;

endmodule
